// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch unit.
// Accepts one word fetch at a time over valid/ready and answers after
// WAIT_STATES extra cycles. A load port fills the array independently of fetches.
module imem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_STATES = 2,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic          rsp_err,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q, busy_q;
  logic [31:0] rsp_instr_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Decode either the live request (IDLE, used when WAIT_STATES==0)
  // or the address captured at acceptance.
  logic [31:0]   dec_addr, dec_off;
  logic          dec_err;
  logic [AW-1:0] dec_idx;

  // Address decode: misaligned, below base, or past the end all flag an error.
  always_comb begin
    dec_addr = (state_q == S_IDLE) ? req_addr : addr_q;
    dec_off  = dec_addr - ADDR_BASE;
    dec_err  = (dec_addr[1:0] != 2'b00) || (dec_addr < ADDR_BASE) ||
               ((dec_off >> 2) >= 32'(DEPTH_WORDS));
    dec_idx  = dec_off[AW+1:2];
  end

  // Program-load write port; never stalls and ignores FSM state.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Fetch FSM with registered outputs. The array read happens on the edge
  // that enters RESP, so a same-edge load still returns the old word.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= dec_err;
              rsp_instr_q <= dec_err ? 32'h0 : mem[dec_idx];
            end else begin
              cnt_q   <= 4'(WAIT_STATES - 1);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= dec_err;
            rsp_instr_q <= dec_err ? 32'h0 : mem[dec_idx];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances with WAIT_STATES = 0, 1, 2,
// each driven through its own signal set indexed by its wait-state count.
module tb_imem_responder;

  logic clk = 1'b0;
  logic RESET = 1'b0;
  always #5 clk = ~clk;

  logic        rv [3];
  logic [31:0] ra [3];
  logic        rr [3];
  logic        le [3];
  logic [11:0] la [3];
  logic [31:0] ld [3];
  logic        qr [3];
  logic        sv [3];
  logic [31:0] si [3];
  logic        se [3];
  logic        bz [3];

  imem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .RESET(RESET), .req_valid(rv[0]), .req_ready(qr[0]), .req_addr(ra[0]),
    .rsp_valid(sv[0]), .rsp_ready(rr[0]), .rsp_instr(si[0]), .rsp_err(se[0]),
    .load_en(le[0]), .load_addr(la[0]), .load_data(ld[0]), .busy(bz[0]));
  imem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .RESET(RESET), .req_valid(rv[1]), .req_ready(qr[1]), .req_addr(ra[1]),
    .rsp_valid(sv[1]), .rsp_ready(rr[1]), .rsp_instr(si[1]), .rsp_err(se[1]),
    .load_en(le[1]), .load_addr(la[1]), .load_data(ld[1]), .busy(bz[1]));
  imem_responder #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .RESET(RESET), .req_valid(rv[2]), .req_ready(qr[2]), .req_addr(ra[2]),
    .rsp_valid(sv[2]), .rsp_ready(rr[2]), .rsp_instr(si[2]), .rsp_err(se[2]),
    .load_en(le[2]), .load_addr(la[2]), .load_data(ld[2]), .busy(bz[2]));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled on falling edges.
  task automatic load_all(input logic [11:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin le[k] = 1'b1; la[k] = idx; ld[k] = data; end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) le[k] = 1'b0;
  endtask

  // One fetch with rsp_ready held high; reports latency, data and whether
  // the cycle after the response shows rsp_valid low again.
  task automatic fetch(input int k, input logic [31:0] addr, output int lat,
                       output logic [31:0] instr, output logic err, output logic pulse_ok);
    lat = 0; instr = 'x; err = 'x; pulse_ok = 1'b0;
    @(posedge clk); #1;
    rv[k] = 1'b1; ra[k] = addr; rr[k] = 1'b1;
    @(posedge clk); #1;           // acceptance edge (DUT idle)
    rv[k] = 1'b0; ra[k] = 32'hFFFF_FFFF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sv[k]) begin lat = c; break; end
    end
    if (lat != 0) begin
      instr = si[k]; err = se[k];
      @(negedge clk);
      pulse_ok = !sv[k] && qr[k] && !bz[k];
    end
  endtask

  vec_t vecs [6];
  int lat; logic [31:0] ins; logic er; logic pok; logic seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rv[k] = 0; ra[k] = 0; rr[k] = 0; le[k] = 0; la[k] = 0; ld[k] = 0;
    end
    vecs[0] = '{32'h0000_3000, 32'h3C01_1234, 1'b0};
    vecs[1] = '{32'h0000_3002, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_2FFC, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_7000, 32'h0000_0000, 1'b1};   // base + 4*4096
    vecs[4] = '{32'h0000_6FFC, 32'hDEAD_BEEF, 1'b0};   // base + 4*4095
    vecs[5] = '{32'h0000_3004, 32'h0000_000C, 1'b0};

    // Reset state
    #12;
    chk("reset req_ready", 32'(qr[2]), 32'd1);
    chk("reset rsp_valid", 32'(sv[2]), 32'd0);
    chk("reset rsp_instr", si[2], 32'h0);
    chk("reset rsp_err",   32'(se[2]), 32'd0);
    chk("reset busy",      32'(bz[2]), 32'd0);
    @(negedge clk); RESET = 1'b1;

    load_all(12'd0,    32'h3C01_1234);
    load_all(12'd1,    32'h0000_000C);
    load_all(12'd4095, 32'hDEAD_BEEF);

    // Vector table on every instance: latency is WAIT_STATES+1
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 6; v++) begin
        fetch(k, vecs[v].addr, lat, ins, er, pok);
        chk($sformatf("ws%0d v%0d latency", k, v), 32'(lat), 32'(k + 1));
        chk($sformatf("ws%0d v%0d instr", k, v), ins, vecs[v].exp_instr);
        chk($sformatf("ws%0d v%0d err", k, v), 32'(er), 32'(vecs[v].exp_err));
        chk($sformatf("ws%0d v%0d pulse", k, v), 32'(pok), 32'd1);
      end
    end

    // Backpressure on WS=2: response holds while rsp_ready is low
    @(posedge clk); #1;
    rv[2] = 1'b1; ra[2] = 32'h0000_3004; rr[2] = 1'b0;
    @(posedge clk); #1;
    rv[2] = 1'b0; ra[2] = 32'h0000_3000;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp rsp_valid", 32'(sv[2]), 32'd1);
      chk("bp rsp_instr", si[2], 32'h0000_000C);
      chk("bp req_ready", 32'(qr[2]), 32'd0);
      if (c < 4) @(negedge clk);
    end
    @(posedge clk); #1; rr[2] = 1'b1;
    @(negedge clk);
    chk("bp valid before handshake edge", 32'(sv[2]), 32'd1);
    @(negedge clk);
    chk("bp idle rsp_valid", 32'(sv[2]), 32'd0);
    chk("bp idle req_ready", 32'(qr[2]), 32'd1);

    // Reset asserted mid-WAIT aborts the fetch
    @(posedge clk); #1;
    rv[2] = 1'b1; ra[2] = 32'h0000_3000;
    @(posedge clk); #1;
    rv[2] = 1'b0;
    @(negedge clk);
    chk("wait busy", 32'(bz[2]), 32'd1);
    chk("wait req_ready", 32'(qr[2]), 32'd0);
    #1 RESET = 1'b0;
    #1;
    chk("async rst rsp_valid", 32'(sv[2]), 32'd0);
    chk("async rst req_ready", 32'(qr[2]), 32'd1);
    chk("async rst busy", 32'(bz[2]), 32'd0);
    @(negedge clk); RESET = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (sv[2]) seen = 1'b1;
    end
    chk("aborted fetch no response", 32'(seen), 32'd0);
    fetch(2, 32'h0000_3000, lat, ins, er, pok);
    chk("post-reset latency", 32'(lat), 32'd3);
    chk("post-reset memory kept", ins, 32'h3C01_1234);

    // Load/read race on WS=1: same-edge load returns the old word
    load_all(12'd5, 32'hAAAA_AAAA);
    @(posedge clk); #1;
    rv[1] = 1'b1; ra[1] = 32'h0000_3014; rr[1] = 1'b1;
    @(posedge clk); #1;           // acceptance
    rv[1] = 1'b0; le[1] = 1'b1; la[1] = 12'd5; ld[1] = 32'hBBBB_BBBB;
    @(posedge clk); #1;           // enters RESP and writes
    le[1] = 1'b0;
    @(negedge clk);
    chk("race rsp_valid", 32'(sv[1]), 32'd1);
    chk("race old word", si[1], 32'hAAAA_AAAA);
    @(negedge clk);
    fetch(1, 32'h0000_3014, lat, ins, er, pok);
    chk("race repeat latency", 32'(lat), 32'd2);
    chk("race new word", ins, 32'hBBBB_BBBB);

    // Zero wait, back-to-back: one fetch every 2 cycles
    @(posedge clk); #1;
    rv[0] = 1'b1; ra[0] = 32'h0000_3004; rr[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b c%0d rsp_valid", c), 32'(sv[0]), 32'(c % 2));
      if (c % 2 == 1) chk($sformatf("b2b c%0d instr", c), si[0], 32'h0000_000C);
    end
    @(posedge clk); #1; rv[0] = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
